// File: rtl/alu_req_arbiter_pkg.sv
// Shared types and constants for the ALU request arbiter.
//   arb_state_t    : arbiter FSM states
//   FLAG_W         : width of the {ERR,OFLOW,COUT,G,L,E} flag bundle
//   ERR_ONLY_FLAGS : flags returned when a request carries no valid operand
package alu_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  localparam int FLAG_W = 6;
  localparam logic [FLAG_W-1:0] ERR_ONLY_FLAGS = 6'b100000;
endpackage

// File: rtl/alu_req_arbiter_if.sv
// Bus bundle for alu_req_arbiter: requester side, ALU pin side, response side.
//   slave  : arbiter view (takes requests, drives ALU inputs, returns responses)
//   master : environment view (requesters, ALU, response consumer)
interface alu_req_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ*DATA_WIDTH-1:0] req_opa;
  logic [N_REQ*DATA_WIDTH-1:0] req_opb;
  logic [N_REQ*CMD_WIDTH-1:0]  req_cmd;
  logic [N_REQ-1:0]            req_mode;
  logic [N_REQ-1:0]            req_cin;
  logic [2*N_REQ-1:0]          req_inpv;

  logic [DATA_WIDTH-1:0]       OPA;
  logic [DATA_WIDTH-1:0]       OPB;
  logic [CMD_WIDTH-1:0]        CMD;
  logic                        MODE;
  logic                        CIN;
  logic                        CE;
  logic [1:0]                  INP_VALID;
  logic [2*DATA_WIDTH-1:0]     RES;
  logic                        ERR, OFLOW, COUT, G, L, E;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [IW-1:0]               rsp_id;
  logic [2*DATA_WIDTH-1:0]     rsp_res;
  logic [FLAG_W-1:0]           rsp_flags;

  modport slave (
    input  req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_inpv,
    input  RES, ERR, OFLOW, COUT, G, L, E, rsp_ready,
    output req_ready, OPA, OPB, CMD, MODE, CIN, CE, INP_VALID,
    output rsp_valid, rsp_id, rsp_res, rsp_flags
  );

  modport master (
    output req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_inpv,
    output RES, ERR, OFLOW, COUT, G, L, E, rsp_ready,
    input  req_ready, OPA, OPB, CMD, MODE, CIN, CE, INP_VALID,
    input  rsp_valid, rsp_id, rsp_res, rsp_flags
  );
endinterface

// File: rtl/alu_req_arbiter_rr.sv
// Round-robin search: grants the first set request bit at or after ptr,
// wrapping from N-1 back to 0. Purely combinational.
//   req     : request vector
//   ptr     : highest-priority index
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the grant
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  localparam int unsigned NU = N;

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = (32'(ptr) + k) % NU;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU among N_REQ requesters, one operation in flight.
// Winner's fields are latched, presented to the ALU with CE for one cycle,
// RES/flags are captured after a command-dependent latency, and returned
// tagged with the requester id until the consumer accepts them.
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   bus        : alu_req_arbiter_if.slave (requests, ALU pins, response)
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int LAT        = 1,
  parameter int MUL_LAT    = 2,
  parameter int MUL_CMD0   = 9,
  parameter int MUL_CMD1   = 10
) (
  input logic              clk,
  input logic              reset,
  alu_req_arbiter_if.slave bus
);
  localparam int IW    = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MUL_LAT + 1);

  arb_state_t            state;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         g;
  logic [CNT_W-1:0]      cnt;
  logic [N_REQ-1:0]      gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  is_mul;

  logic [DATA_WIDTH-1:0] sel_opa, sel_opb;
  logic [CMD_WIDTH-1:0]  sel_cmd;
  logic                  sel_mode, sel_cin;
  logic [1:0]            sel_inpv;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Accept pulse is combinational so the grant and the latch share one cycle;
  // gated by reset so nothing is offered while reset is held.
  assign bus.req_ready = (state == IDLE && !reset) ? gnt : '0;

  always_comb begin
    sel_opa  = bus.req_opa[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    sel_opb  = bus.req_opb[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    sel_cmd  = bus.req_cmd[gnt_idx*CMD_WIDTH +: CMD_WIDTH];
    sel_mode = bus.req_mode[gnt_idx];
    sel_cin  = bus.req_cin[gnt_idx];
    sel_inpv = bus.req_inpv[gnt_idx*2 +: 2];
  end

  assign is_mul = bus.MODE && (bus.CMD == CMD_WIDTH'(MUL_CMD0) ||
                               bus.CMD == CMD_WIDTH'(MUL_CMD1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      g             <= '0;
      cnt           <= '0;
      bus.OPA       <= '0;
      bus.OPB       <= '0;
      bus.CMD       <= '0;
      bus.MODE      <= 1'b0;
      bus.CIN       <= 1'b0;
      bus.CE        <= 1'b0;
      bus.INP_VALID <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_res   <= '0;
      bus.rsp_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            g             <= gnt_idx;
            bus.OPA       <= sel_opa;
            bus.OPB       <= sel_opb;
            bus.CMD       <= sel_cmd;
            bus.MODE      <= sel_mode;
            bus.CIN       <= sel_cin;
            bus.INP_VALID <= sel_inpv;
            // An op with no valid operand still passes through ISSUE (keeping
            // its 2-cycle response latency) but never enables the ALU.
            bus.CE        <= |sel_inpv;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.CE <= 1'b0;
          if (bus.INP_VALID == 2'b00) begin
            bus.rsp_res   <= '0;
            bus.rsp_flags <= ERR_ONLY_FLAGS;
            bus.rsp_id    <= g;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            cnt   <= is_mul ? CNT_W'(MUL_LAT - 1) : CNT_W'(LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            bus.rsp_res   <= bus.RES;
            bus.rsp_flags <= {bus.ERR, bus.OFLOW, bus.COUT, bus.G, bus.L, bus.E};
            bus.rsp_id    <= g;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            rr_ptr        <= (g == IW'(N_REQ - 1)) ? '0 : g + 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
